// File: rtl/frame_sched.sv
// Reads a frame word by word from the packet buffer and sends each word as lo/hi bytes over a valid/ready link; ob_abort rewinds and replays the frame.
// Optional FRAME_SCHED_SYNC_EN adds a FF,FF,FF,7F preamble per frame; every byte holds until ob_ready accepts it.
module frame_sched #(
  parameter int FRAME_WORDS = 8,
  parameter int SETTLE      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FrameReady,
  input  logic [15:0] DataVal,
  output logic        DataNext,
  output logic        DataFrameReset,
  output logic [7:0]  ob_data,
  output logic        ob_valid,
  input  logic        ob_ready,
  input  logic        ob_abort,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int IW = $clog2(FRAME_WORDS) + 1;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [IW-1:0] WORDS       = IW'(FRAME_WORDS);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] SETTLE_END  = CW'(SETTLE);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_SEND_LO = 3'd2;
  localparam logic [2:0] S_SEND_HI = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_SETTLE  = 3'd5;
  localparam logic [2:0] S_REWIND  = 3'd6;
`ifdef FRAME_SCHED_SYNC_EN
  localparam logic [2:0] S_SYNC    = 3'd7;
`endif

  logic [2:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_hold;
  logic [15:0]   r_frame_cnt;
`ifdef FRAME_SCHED_SYNC_EN
  logic [1:0]    r_sync_idx;
`endif

  logic       w_valid;
  logic [7:0] w_data;
  logic       w_xfer;
  logic       w_abort;

  always_comb begin
    w_valid = 1'b0;
    w_data  = 8'h00;
    case (r_state)
      S_SEND_LO: begin
        w_valid = 1'b1;
        w_data  = r_hold[7:0];
      end
      S_SEND_HI: begin
        w_valid = 1'b1;
        w_data  = r_hold[15:8];
      end
`ifdef FRAME_SCHED_SYNC_EN
      S_SYNC: begin
        w_valid = 1'b1;
        w_data  = (r_sync_idx == 2'd3) ? 8'h7F : 8'hFF;
      end
`endif
      default: ;
    endcase
  end

  // Outputs are forced to their idle values for the whole time rst is high, not just after the first edge.
  assign ob_valid       = w_valid && !rst;
  assign ob_data        = rst ? 8'h00 : w_data;
  assign DataNext       = (r_state == S_ADVANCE) && !rst;
  assign DataFrameReset = (r_state == S_REWIND) && (r_cnt == '0) && !rst;
  assign busy           = (r_state != S_IDLE) && !rst;
  assign frame_cnt      = rst ? 16'h0000 : r_frame_cnt;

  assign w_xfer  = ob_valid && ob_ready;
  assign w_abort = ob_abort && (r_state != S_IDLE) && (r_state != S_REWIND);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_hold      <= 16'h0000;
      r_frame_cnt <= 16'h0000;
`ifdef FRAME_SCHED_SYNC_EN
      r_sync_idx  <= 2'd0;
`endif
    end else if (w_abort) begin
      r_state <= S_REWIND;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (FrameReady) begin
            r_idx <= '0;
`ifdef FRAME_SCHED_SYNC_EN
            r_sync_idx <= 2'd0;
            r_state    <= S_SYNC;
`else
            r_state <= S_CAPTURE;
`endif
          end
        end
`ifdef FRAME_SCHED_SYNC_EN
        S_SYNC: begin
          if (w_xfer) begin
            r_sync_idx <= r_sync_idx + 2'd1;
            if (r_sync_idx == 2'd3) r_state <= S_CAPTURE;
          end
        end
`endif
        S_CAPTURE: begin
          r_hold  <= DataVal;
          r_state <= S_SEND_LO;
        end
        S_SEND_LO: if (w_xfer) r_state <= S_SEND_HI;
        S_SEND_HI: if (w_xfer) r_state <= S_ADVANCE;
        S_ADVANCE: begin
          r_idx   <= r_idx + IW'(1);
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt <= '0;
            if (r_idx < WORDS) begin
              r_state <= S_CAPTURE;
            end else begin
              r_state     <= S_IDLE;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // One DataFrameReset cycle (cnt==0) followed by SETTLE quiet cycles.
        S_REWIND: begin
          if (r_cnt == SETTLE_END) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: behavioural packet buffer, byte scoreboard, table of frame scenarios plus reset/abort corner sequences.
module tb_frame_sched;

  localparam int FW = 8;
  localparam int ST = 2;
`ifdef FRAME_SCHED_SYNC_EN
  localparam int SB = 4;
`else
  localparam int SB = 0;
`endif

  logic        clk;
  logic        rst;
  logic        FrameReady;
  logic [15:0] DataVal;
  logic        DataNext;
  logic        DataFrameReset;
  logic [7:0]  ob_data;
  logic        ob_valid;
  logic        ob_ready;
  logic        ob_abort;
  logic        busy;
  logic [15:0] frame_cnt;

  frame_sched #(.FRAME_WORDS(FW), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .FrameReady(FrameReady), .DataVal(DataVal),
    .DataNext(DataNext), .DataFrameReset(DataFrameReset),
    .ob_data(ob_data), .ob_valid(ob_valid), .ob_ready(ob_ready),
    .ob_abort(ob_abort), .busy(busy), .frame_cnt(frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Packet buffer model: frame k holds words {0x11*(k+1), w}.
  int   pos;
  int   frames_loaded;
  logic fr_mask;
  logic prev_dn_b;

  function automatic logic [15:0] word_at(input int p);
    return {8'(17 * ((p >> 3) + 1)), 8'(p & 7)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pos        <= 0;
      prev_dn_b  <= 1'b0;
      DataVal    <= 16'h0000;
      FrameReady <= 1'b0;
    end else begin
      prev_dn_b <= DataNext;
      if (DataNext && !prev_dn_b) pos <= pos + 1;
      else if (DataFrameReset) pos <= pos & ~(FW - 1);
      DataVal    <= word_at(pos);
      FrameReady <= !fr_mask && ((pos >> 3) < frames_loaded);
    end
  end

  logic [7:0] q[$];

  task automatic push_frame(input int k);
    if (SB != 0) begin
      q.push_back(8'hFF); q.push_back(8'hFF); q.push_back(8'hFF); q.push_back(8'h7F);
    end
    for (int w = 0; w < FW; w++) begin
      q.push_back(8'(w));
      q.push_back(8'(17 * (k + 1)));
    end
  endtask

  // Monitor sits on the falling edge, seeing exactly what the next rising edge will act on.
  int         bytes_vec, dn_vec, dfr_vec, gap;
  logic       p_valid, p_ready, p_dn;
  logic [7:0] p_data;

  initial begin
    gap = 100; p_valid = 0; p_ready = 0; p_dn = 0; p_data = 0;
    bytes_vec = 0; dn_vec = 0; dfr_vec = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      p_valid = 1'b0; p_dn = 1'b0; gap = 100;
    end else begin
      if (ob_valid && ob_ready) begin
        bytes_vec++;
        chk("byte_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) chk("byte", 32'(ob_data), 32'(q.pop_front()));
      end
      if (ob_valid && p_valid && !p_ready) chk("hold_stable", 32'(ob_data), 32'(p_data));
      if (DataNext) begin
        dn_vec++;
        chk("dn_width", 32'(p_dn), 0);
        if (!p_dn) chk("dn_gap", 32'(gap >= ST), 1);
        gap = 0;
      end else begin
        gap++;
      end
      if (DataFrameReset) dfr_vec++;
      if (DataNext || DataFrameReset) chk("dn_dfr_excl", 32'(DataNext && DataFrameReset), 0);
      p_valid = ob_valid; p_ready = ob_ready; p_data = ob_data; p_dn = DataNext;
    end
  end

  typedef struct {
    int new_frames;
    int rmode;       // 0 ready high, 1 pattern 1,0,0,1, 2 random
    int abort_at;    // abort after this many DataNext pulses, 0 = none
    int mask_mid;    // drop FrameReady once the frame has started
    int exp_data;    // data bytes, preamble bytes added per sent frame
    int exp_dn;
    int exp_dfr;
    int exp_dfc;
  } vec_t;

  vec_t vt[6];
  int   exp_fcnt;

  task automatic run_vec(input vec_t v, input int id);
    int  idle_run;
    bit  done;
    bit  aborted;
    bytes_vec = 0; dn_vec = 0; dfr_vec = 0;
    aborted = 0; done = 0; idle_run = 0;
    for (int f = 0; f < v.new_frames; f++) push_frame(frames_loaded + f);
    frames_loaded += v.new_frames;
    exp_fcnt += v.exp_dfc;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clk); #1;
      case (v.rmode)
        0: ob_ready = 1'b1;
        1: ob_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: ob_ready = 1'($urandom_range(0, 1));
      endcase
      ob_abort = 1'b0;
      if (v.abort_at != 0 && !aborted && dn_vec == v.abort_at) begin
        ob_abort = 1'b1;
        ob_ready = 1'b0;
        aborted  = 1;
        q.delete();
        push_frame(frames_loaded - 1);
      end
      if (v.mask_mid != 0 && bytes_vec >= 1) fr_mask = 1'b1;
      if (frame_cnt == 16'(exp_fcnt) && !busy && q.size() == 0) idle_run++;
      else idle_run = 0;
      if (idle_run >= 20) done = 1;
    end
    ob_abort = 1'b0;
    fr_mask  = 1'b0;
    @(negedge clk);
    $display("vector %0d checked", id);
    chk("vec_done", 32'(done), 1);
    chk("vec_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    chk("vec_bytes", 32'(bytes_vec), 32'(v.exp_data + SB * (v.new_frames + v.exp_dfr)));
    chk("vec_datanext", 32'(dn_vec), 32'(v.exp_dn));
    chk("vec_framereset", 32'(dfr_vec), 32'(v.exp_dfr));
    chk("vec_queue_empty", 32'(q.size()), 0);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; ob_ready = 1'b0; ob_abort = 1'b0;
    frames_loaded = 0; fr_mask = 1'b0; exp_fcnt = 0;

    vt[0] = '{1, 0, 0, 0, 16,  8, 0, 1};
    vt[1] = '{1, 1, 0, 0, 16,  8, 0, 1};
    vt[2] = '{1, 0, 5, 0, 26, 13, 1, 1};
    vt[3] = '{2, 2, 0, 0, 32, 16, 0, 2};
    vt[4] = '{0, 0, 0, 0,  0,  0, 0, 0};
    vt[5] = '{1, 0, 0, 1, 16,  8, 0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_datanext", 32'(DataNext), 0);
    chk("rst_framereset", 32'(DataFrameReset), 0);
    chk("rst_ob_valid", 32'(ob_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ob_data", 32'(ob_data), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // Abort while idle must be ignored.
    dfr_vec = 0;
    @(posedge clk); #1;
    ob_abort = 1'b1;
    repeat (3) @(posedge clk);
    #1 ob_abort = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_abort_dfr", 32'(dfr_vec), 0);
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));

    // Reset while holding the high byte of the first word.
    bytes_vec = 0; hit = 0;
    push_frame(frames_loaded);
    frames_loaded++;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(posedge clk); #1;
      if (bytes_vec >= 1 + SB) begin
        ob_ready = 1'b0;
        hit = 1;
      end else begin
        ob_ready = 1'b1;
      end
    end
    chk("reach_send_hi", 32'(hit), 1);
    @(negedge clk);
    chk("send_hi_valid", 32'(ob_valid), 1);
    if (q.size() > 0) chk("send_hi_data", 32'(ob_data), 32'(q[0]));
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    frames_loaded = 0;
    exp_fcnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ob_valid", 32'(ob_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ob_data", 32'(ob_data), 0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 0);
    chk("midrst_datanext", 32'(DataNext), 0);
    chk("midrst_framereset", 32'(DataFrameReset), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ob_ready = 1'b1;
    bytes_vec = 0; dfr_vec = 0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("post_rst_no_bytes", 32'(bytes_vec), 0);
    chk("post_rst_no_dfr", 32'(dfr_vec), 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
